// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants, TX FSM state encoding and helpers for
// the UART command decoder.
package uart_cmd_pkg;

  // ASCII command characters (lowercase forms).
  localparam logic [7:0] CH_U = 8'h75;
  localparam logic [7:0] CH_D = 8'h64;
  localparam logic [7:0] CH_R = 8'h72;
  localparam logic [7:0] CH_L = 8'h6C;
  localparam logic [7:0] CH_X = 8'h78;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_3 = 8'h33;

  // Echo transmitter states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  // Cycles WAIT_BUSY waits for tx_busy to rise before giving up.
  localparam int BUSY_TIMEOUT = 4;

  // Map 'A'..'Z' onto 'a'..'z'; every other byte passes through.
  function automatic logic [7:0] to_lower(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return b | 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/cmd_echo_fifo.sv
// cmd_echo_fifo: small synchronous FIFO holding bytes waiting to be echoed.
// DEPTH must be a power of two (pointers wrap naturally). A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module cmd_echo_fifo
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns received ASCII bytes into one-cycle button pulses,
// a switch-override register and error pulses (latency 1 from rx_done).
// Build option CMD_ECHO_EN adds an echo FIFO and a transmit FSM; without it
// tx_start, tx_data and echo_ovf are tied to zero and tx_busy is ignored.
//
// Transmit handshake: tx_start is a one-cycle request with tx_data already
// valid; the transmitter answers by raising tx_busy and the byte counts as
// sent when tx_busy falls again. tx_data stays stable until then. If tx_busy
// never rises within BUSY_TIMEOUT cycles the request is abandoned.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int ECHO_DEPTH   = 4,
  parameter int ACCEPT_UPPER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       cmd_btn_u,
  output logic       cmd_btn_d,
  output logic       cmd_btn_r,
  output logic       cmd_btn_l,
  output logic [3:0] cmd_sw,
  output logic       cmd_err,
  output logic       echo_ovf,
  output logic [1:0] dbg_tx_state
);

  logic [7:0] w_byte;
  logic       w_is_u, w_is_d, w_is_r, w_is_l, w_is_x, w_is_sw, w_known;
  logic       r_btn_u, r_btn_d, r_btn_r, r_btn_l, r_err;
  logic [3:0] r_sw;

  assign w_byte  = (ACCEPT_UPPER != 0) ? to_lower(rx_data) : rx_data;
  assign w_is_u  = (w_byte == CH_U);
  assign w_is_d  = (w_byte == CH_D);
  assign w_is_r  = (w_byte == CH_R);
  assign w_is_l  = (w_byte == CH_L);
  assign w_is_x  = (w_byte == CH_X);
  assign w_is_sw = (w_byte >= CH_0) && (w_byte <= CH_3);
  assign w_known = w_is_u | w_is_d | w_is_r | w_is_l | w_is_x | w_is_sw;

  // Decode register: pulses last one cycle, switch bits hold between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_u <= 1'b0;
      r_btn_d <= 1'b0;
      r_btn_r <= 1'b0;
      r_btn_l <= 1'b0;
      r_err   <= 1'b0;
      r_sw    <= 4'b0000;
    end else begin
      r_btn_u <= rx_done && w_is_u;
      r_btn_d <= rx_done && w_is_d;
      r_btn_r <= rx_done && w_is_r;
      r_btn_l <= rx_done && w_is_l;
      r_err   <= rx_done && !w_known;
      if (rx_done && w_is_sw)     r_sw[w_byte[1:0]] <= ~r_sw[w_byte[1:0]];
      else if (rx_done && w_is_x) r_sw <= 4'b0000;
    end
  end

  assign cmd_btn_u = r_btn_u;
  assign cmd_btn_d = r_btn_d;
  assign cmd_btn_r = r_btn_r;
  assign cmd_btn_l = r_btn_l;
  assign cmd_err   = r_err;
  assign cmd_sw    = r_sw;

`ifdef CMD_ECHO_EN
  tx_state_e  r_state, w_next;
  logic       w_pop, w_full, w_empty;
  logic [7:0] w_head;
  logic [2:0] r_wait_cnt;
  logic       r_tx_start, r_ovf;
  logic [7:0] r_tx_data;

  cmd_echo_fifo #(.DEPTH(ECHO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (rx_done),
    .i_data  (rx_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Next-state logic: pop and request only from IDLE with the line free.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop  = 1'b1;
          w_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) w_next = WAIT_DONE;
        else if (r_wait_cnt == 3'(BUSY_TIMEOUT - 1)) w_next = IDLE;
      end
      WAIT_DONE: begin
        if (!tx_busy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, request strobe, held data byte, timeout counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_wait_cnt <= 3'd0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= w_head;
      r_wait_cnt <= (r_state == WAIT_BUSY) ? r_wait_cnt + 3'd1 : 3'd0;
      if (rx_done && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign echo_ovf     = r_ovf;
  assign dbg_tx_state = r_state;
`else
  logic [1:0] w_unused_cfg;

  assign w_unused_cfg = {tx_busy, ECHO_DEPTH[0]};
  assign tx_start     = 1'b0;
  assign tx_data      = 8'h00;
  assign echo_ovf     = 1'b0;
  assign dbg_tx_state = 2'b00;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed bench for uart_cmd_decoder with a
// cycle-level reference model and per-cycle output comparison.
// Echo checks are active when CMD_ECHO_EN is defined.
module tb_uart_cmd_decoder;

  localparam int ECHO_DEPTH   = 4;
  localparam int ACCEPT_UPPER = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       cmd_btn_u, cmd_btn_d, cmd_btn_r, cmd_btn_l;
  logic [3:0] cmd_sw;
  logic       cmd_err;
  logic       echo_ovf;
  logic [1:0] dbg_tx_state;

  int errors = 0;
  int checks = 0;

  // Model state
  logic       exp_u = 0, exp_d = 0, exp_r = 0, exp_l = 0, exp_err = 0;
  logic [3:0] exp_sw = 0;
  logic       exp_ovf = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  logic       prev_start = 0;
  bit         busy_force = 0;
  int         busy_cnt = 0;

  uart_cmd_decoder #(.ECHO_DEPTH(ECHO_DEPTH), .ACCEPT_UPPER(ACCEPT_UPPER)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .cmd_btn_u    (cmd_btn_u),
    .cmd_btn_d    (cmd_btn_d),
    .cmd_btn_r    (cmd_btn_r),
    .cmd_btn_l    (cmd_btn_l),
    .cmd_sw       (cmd_sw),
    .cmd_err      (cmd_err),
    .echo_ovf     (echo_ovf),
    .dbg_tx_state (dbg_tx_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter stand-in: busy for 20 cycles after each request, or forced busy.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) busy_cnt = 20;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = busy_force || (busy_cnt > 0);
    end
  end

  // Reference model: outputs after an edge follow from the byte captured there.
  // The echo queue holds bytes accepted but not yet seen on tx_start; overflow
  // is predicted only from its occupancy.
  always @(posedge clk) begin
    logic [7:0] b;
    int idx;
    exp_u = 0; exp_d = 0; exp_r = 0; exp_l = 0; exp_err = 0;
    if (rst) begin
      exp_sw  = 0;
      exp_ovf = 0;
      exp_q.delete();
    end else if (rx_done) begin
      b = rx_data;
      if (ACCEPT_UPPER != 0 && b >= "A" && b <= "Z") b = b + 8'd32;
      case (b)
        "u": exp_u = 1;
        "d": exp_d = 1;
        "r": exp_r = 1;
        "l": exp_l = 1;
        "x": exp_sw = 4'b0000;
        "0", "1", "2", "3": begin
          idx = int'(b) - 48;
          exp_sw[idx] = ~exp_sw[idx];
        end
        default: exp_err = 1;
      endcase
`ifdef CMD_ECHO_EN
      if (exp_q.size() < ECHO_DEPTH) exp_q.push_back(rx_data);
      else exp_ovf = 1;
`endif
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("btn_u", cmd_btn_u, exp_u);
    check("btn_d", cmd_btn_d, exp_d);
    check("btn_r", cmd_btn_r, exp_r);
    check("btn_l", cmd_btn_l, exp_l);
    check("err", cmd_err, exp_err);
    check("sw", cmd_sw, exp_sw);
    check("ovf", echo_ovf, exp_ovf);
`ifdef CMD_ECHO_EN
    if (tx_start === 1'b1) begin
      check("start_gap", prev_start, 1'b0);
      check("start_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
      tx_log.push_back(tx_data);
    end
`else
    check("tx_start_tied", tx_start, 1'b0);
    check("tx_data_tied", tx_data, 8'h00);
`endif
    prev_start = tx_start;
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_burst(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      @(posedge clk); #1;
      rx_data = bytes[i];
      rx_done = 1'b1;
    end
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", n < 3000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Directed stimulus with literal expectations
  initial begin
    logic [7:0] burst[$];
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_sw", cmd_sw, 4'b0000);
    check("rst_start", tx_start, 1'b0);
    check("rst_ovf", echo_ovf, 1'b0);

    // Single button command
    send_byte(8'h72);
    check("r_pulse", cmd_btn_r, 1'b1);
    check("r_other_u", cmd_btn_u, 1'b0);
    check("r_other_l", cmd_btn_l, 1'b0);
    @(posedge clk); #1;
    check("r_one_cycle", cmd_btn_r, 1'b0);
    drain();

    // Switch toggles and clear
    send_byte("0"); check("sw_0", cmd_sw, 4'b0001);
    send_byte("2"); check("sw_02", cmd_sw, 4'b0101);
    send_byte("0"); check("sw_020", cmd_sw, 4'b0100);
    send_byte("x"); check("sw_x", cmd_sw, 4'b0000);
    drain();

    // Error bytes and uppercase
    send_byte(8'h41); check("err_A", cmd_err, 1'b1);
    send_byte("U");   check("btn_U", cmd_btn_u, 1'b1);
    check("U_no_err", cmd_err, 1'b0);
    send_byte(8'h0D); check("err_cr", cmd_err, 1'b1);
    check("cr_sw_kept", cmd_sw, 4'b0000);
    drain();

    // Back-to-back echo
    tx_log.delete();
    burst = '{8'h72, 8'h72, 8'h75};
    send_burst(burst);
    check("b2b_last_u", cmd_btn_u, 1'b1);
    drain();
`ifdef CMD_ECHO_EN
    check("echo_count", 8'(tx_log.size()), 8'd3);
    check("echo_0", tx_log[0], 8'h72);
    check("echo_1", tx_log[1], 8'h72);
    check("echo_2", tx_log[2], 8'h75);
`else
    check("echo_count", 8'(tx_log.size()), 8'd0);
`endif
    check("echo_no_ovf", echo_ovf, 1'b0);

    // Overflow with the transmitter held busy
    busy_force = 1;
    repeat (2) @(posedge clk);
    tx_log.delete();
    burst = '{"d", "l", "r", "u", "d", "l"};
    send_burst(burst);
`ifdef CMD_ECHO_EN
    check("ovf_set", echo_ovf, 1'b1);
`else
    check("ovf_tied", echo_ovf, 1'b0);
`endif
    busy_force = 0;
    drain();
`ifdef CMD_ECHO_EN
    check("ovf_count", 8'(tx_log.size()), 8'd4);
    check("ovf_0", tx_log[0], "d");
    check("ovf_1", tx_log[1], "l");
    check("ovf_2", tx_log[2], "r");
    check("ovf_3", tx_log[3], "u");
    check("ovf_sticky", echo_ovf, 1'b1);
`endif

    // Reset while a byte is in flight and others are queued
    burst = '{"1", "r", "u"};
    send_burst(burst);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_start", tx_start, 1'b0);
    check("mid_rst_sw", cmd_sw, 4'b0000);
    check("mid_rst_ovf", echo_ovf, 1'b0);
    tx_log.delete();
    drain();
    check("mid_rst_fifo_empty", 8'(tx_log.size()), 8'd0);
    send_byte("d");
    check("after_rst_d", cmd_btn_d, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver inside uart_top.
- Consumes each received byte and turns ASCII commands into one-cycle button pulses and switch-override bits for the watch/stopwatch control path.
- Optionally echoes every received byte back through the UART transmitter.
- Its outputs are ORed with the debounced physical btn_u/btn_d/btn_r/btn_l and XORed with sw[3:0] before the control unit.

Parameters:
- ECHO_DEPTH, 4, echo FIFO entries; must be a power of 2, minimum 2.
- ACCEPT_UPPER, 1, when 1, uppercase 'U','D','R','L','X' decode the same as lowercase.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid while rx_done=1
- rx_done  in  1  one-cycle strobe from the UART receiver
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls
- cmd_btn_u  out  1  one-cycle pulse on 'u' (0x75)
- cmd_btn_d  out  1  one-cycle pulse on 'd' (0x64)
- cmd_btn_r  out  1  one-cycle pulse on 'r' (0x72)
- cmd_btn_l  out  1  one-cycle pulse on 'l' (0x6C)
- cmd_sw  out  4  switch-override register
- cmd_err  out  1  one-cycle pulse on an unrecognised byte
- echo_ovf  out  1  sticky; set when an echo byte is dropped

Behaviour:
- Reset: all outputs are 0, FIFO is empty, FSM is in IDLE. Reset is synchronous and active-high. Reset asserted mid-transfer drops tx_start immediately and discards the FIFO contents.
- Capture: on the clk edge where rx_done=1, rx_data is decoded. The resulting pulse or cmd_sw update is visible in the next cycle (latency 1).
- Button decode: 'u','d','r','l' (plus uppercase if ACCEPT_UPPER) drive exactly one matching cmd_btn_* high for exactly one cycle.
- Switch decode:
  - '0'..'3' (0x30..0x33) toggle cmd_sw[n].
  - 'x' (0x78) clears cmd_sw to 4'b0000.
  - cmd_sw holds its value between commands.
- Errors: any other byte, including CR/LF, pulses cmd_err for one cycle and leaves all other outputs unchanged.
- Back-to-back bytes: rx_done on consecutive cycles produces consecutive pulses. No byte is lost in decode.
- Echo FIFO: every byte captured is pushed, including bytes that raise cmd_err.
  - Full FIFO with no pop in the same cycle: the byte is not stored and echo_ovf is set. echo_ovf clears only on rst.
  - Push into a full FIFO while a pop happens in the same cycle succeeds.
  - Pointers wrap modulo ECHO_DEPTH.
- TX FSM:
  - IDLE: if the FIFO is not empty and tx_busy=0, assert tx_start for 1 cycle, latch the head byte into tx_data, pop the FIFO, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. If tx_busy has not risen within 4 cycles, go to IDLE.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - tx_start is never asserted in consecutive cycles.

Optional Feature:
- CMD_ECHO_EN defined: echo FIFO and TX FSM are present, as described above.
- CMD_ECHO_EN undefined: no FIFO and no FSM. tx_start=0, tx_data=8'h00 and echo_ovf=0 constant. tx_busy is ignored. Decode behaviour is unchanged.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants: CH_U, CH_D, CH_R, CH_L, CH_X, CH_0, CH_3.
  - TX FSM state encodings: IDLE, WAIT_BUSY, WAIT_DONE.
  - WAIT_BUSY timeout constant (4).
- One sub-module, cmd_echo_fifo: synchronous FIFO with push, pop, full, empty and head data. It is instantiated only under CMD_ECHO_EN.

Test Plan:
- Reset then 'r' (0x72) on rx_done -> cmd_btn_r=1 for exactly 1 cycle, 1 cycle after the strobe; the other cmd_btn_* stay 0.
- Sequence '0','2','0' -> cmd_sw = 0001, then 0101, then 0100; then 'x' -> 0000.
- Byte 0x41 ('A') with ACCEPT_UPPER=1 -> cmd_err pulse; byte 'U' -> cmd_btn_u pulse.
- CMD_ECHO_EN, tx_busy model high for 20 cycles after each tx_start, send 'r','r','u' back-to-back -> tx_data sequence 0x72, 0x72, 0x75; one tx_start per byte; echo_ovf=0.
- CMD_ECHO_EN, ECHO_DEPTH=4, tx_busy held 1, 6 bytes sent -> 4 bytes retained, echo_ovf=1. Releasing tx_busy transmits the 4 oldest bytes in order.
- rst asserted during WAIT_DONE -> next cycle tx_start=0, FIFO empty, cmd_sw=0; the next 'd' decodes normally.
